nand_toggle_gen: RTL and testbench

NAND_TOGGLE_GEN -- requirements
Module: nand_toggle_gen

---
 rtl/nand_toggle_gen_if.sv | 38 +++
 rtl/nand_toggle_gen.sv | 140 ++++++++++++++
 tb/tb_nand_toggle_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nand_toggle_gen_if.sv
// rtl/nand_toggle_gen_if.sv - request/drive bundle for nand_toggle_gen (abort present with TOGGLE_ABORT_EN)
interface nand_toggle_gen_if #(
  parameter int VEC_W = 5,
  parameter int CNT_W = 12,
  parameter int DLY_W = 4
);
  logic             start;
`ifdef TOGGLE_ABORT_EN
  logic             abort;
`endif
  logic [CNT_W-1:0] cnt_upto;
  logic [DLY_W-1:0] setup_cycles;
  logic [DLY_W-1:0] hold_cycles;
  logic [VEC_W-1:0] setup_vec;
  logic [VEC_W-1:0] hold_vec;
  logic [VEC_W-1:0] idle_vec;
  logic [VEC_W-1:0] out_vec;
  logic             busy;
  logic             done;
  logic             toggle_stb;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
`ifdef TOGGLE_ABORT_EN
    output abort,
`endif
    output start, cnt_upto, setup_cycles, hold_cycles, setup_vec, hold_vec, idle_vec,
    input  out_vec, busy, done, toggle_stb, toggle_cnt
  );

  modport slave (
`ifdef TOGGLE_ABORT_EN
    input  abort,
`endif
    input  start, cnt_upto, setup_cycles, hold_cycles, setup_vec, hold_vec, idle_vec,
    output out_vec, busy, done, toggle_stb, toggle_cnt
  );
endinterface

// File: rtl/nand_toggle_gen.sv
// rtl/nand_toggle_gen.sv - setup/hold toggle sequence generator; optional abort via TOGGLE_ABORT_EN
module nand_toggle_gen #(
  parameter int VEC_W = 5,
  parameter int CNT_W = 12,
  parameter int DLY_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  nand_toggle_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DLY_W:0]   PH_ONE  = (DLY_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_upto_q, cnt_upto_d;
  logic [DLY_W-1:0] setup_len_q, setup_len_d;
  logic [DLY_W-1:0] hold_len_q, hold_len_d;
  logic [VEC_W-1:0] setup_vec_q, setup_vec_d;
  logic [VEC_W-1:0] hold_vec_q, hold_vec_d;
  // One bit wider than the length inputs so the longest phase never wraps
  logic [DLY_W:0]   phase_q, phase_d;
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [VEC_W-1:0] out_vec_q, out_vec_d;
  logic             done_q, done_d;
  logic             toggle_stb_q, toggle_stb_d;

  logic [DLY_W:0]   setup_eff, hold_eff;
  logic             setup_last, hold_last;
  logic             running;

  // Zero-length phases are stretched to one cycle
  assign setup_eff  = (setup_len_q == '0) ? PH_ONE : {1'b0, setup_len_q};
  assign hold_eff   = (hold_len_q == '0)  ? PH_ONE : {1'b0, hold_len_q};
  assign setup_last = (phase_q == setup_eff - PH_ONE);
  assign hold_last  = (phase_q == hold_eff - PH_ONE);
  assign running    = (state_q == ST_SETUP) || (state_q == ST_HOLD);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; abort overrides any phase transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.cnt_upto == '0) ? ST_DONE : ST_SETUP;
      ST_SETUP: if (setup_last) state_d = ST_HOLD;
      ST_HOLD:  if (hold_last) state_d = (toggle_cnt_q == cnt_upto_q) ? ST_DONE : ST_SETUP;
      ST_DONE:  if (!bus.start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef TOGGLE_ABORT_EN
    if (running && bus.abort) state_d = ST_DONE;
`endif
  end

  // Next values for latched config, counters and registered outputs, keyed off state_d
  always_comb begin
    cnt_upto_d   = cnt_upto_q;
    setup_len_d  = setup_len_q;
    hold_len_d   = hold_len_q;
    setup_vec_d  = setup_vec_q;
    hold_vec_d   = hold_vec_q;
    toggle_cnt_d = toggle_cnt_q;
    phase_d      = '0;
    toggle_stb_d = 1'b0;
    done_d       = (state_d == ST_DONE);

    if (state_q == ST_IDLE && bus.start) begin
      cnt_upto_d   = bus.cnt_upto;
      setup_len_d  = bus.setup_cycles;
      hold_len_d   = bus.hold_cycles;
      setup_vec_d  = bus.setup_vec;
      hold_vec_d   = bus.hold_vec;
      toggle_cnt_d = '0;
    end

    if ((state_d == ST_SETUP || state_d == ST_HOLD) && state_d == state_q)
      phase_d = phase_q + PH_ONE;

    if (state_q == ST_SETUP && state_d == ST_HOLD) begin
      toggle_stb_d = 1'b1;
      toggle_cnt_d = toggle_cnt_q + CNT_ONE;
    end

    // The setup vector is taken straight from the input on the latching edge
    case (state_d)
      ST_SETUP: out_vec_d = (state_q == ST_IDLE) ? bus.setup_vec : setup_vec_q;
      ST_HOLD:  out_vec_d = hold_vec_q;
      default:  out_vec_d = bus.idle_vec;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_upto_q   <= '0;
      setup_len_q  <= '0;
      hold_len_q   <= '0;
      setup_vec_q  <= '0;
      hold_vec_q   <= '0;
      phase_q      <= '0;
      toggle_cnt_q <= '0;
      out_vec_q    <= '0;
      done_q       <= 1'b0;
      toggle_stb_q <= 1'b0;
    end else begin
      cnt_upto_q   <= cnt_upto_d;
      setup_len_q  <= setup_len_d;
      hold_len_q   <= hold_len_d;
      setup_vec_q  <= setup_vec_d;
      hold_vec_q   <= hold_vec_d;
      phase_q      <= phase_d;
      toggle_cnt_q <= toggle_cnt_d;
      out_vec_q    <= out_vec_d;
      done_q       <= done_d;
      toggle_stb_q <= toggle_stb_d;
    end
  end

  // Output drive
  always_comb begin
    bus.busy       = running;
    bus.out_vec    = out_vec_q;
    bus.done       = done_q;
    bus.toggle_stb = toggle_stb_q;
    bus.toggle_cnt = toggle_cnt_q;
  end

endmodule

// File: tb/tb_nand_toggle_gen.sv
// tb/tb_nand_toggle_gen.sv - table-driven bench for nand_toggle_gen
module tb_nand_toggle_gen;

  localparam logic [4:0] SV = 5'h0A;
  localparam logic [4:0] HV = 5'h15;
  localparam logic [4:0] IV = 5'h11;

  typedef struct {
    logic [11:0] cnt;
    logic [3:0]  su;
    logic [3:0]  ho;
    int          n_done;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t tbl[6];

  nand_toggle_gen_if #(.VEC_W(5), .CNT_W(12), .DLY_W(4)) bus ();

  nand_toggle_gen #(.VEC_W(5), .CNT_W(12), .DLY_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents a request, pulses (or holds) start; returns at the negedge after the latching edge
  task automatic start_seq(input logic [11:0] cnt, input logic [3:0] su, input logic [3:0] ho,
                           input logic keep);
    @(negedge clk);
    bus.cnt_upto     = cnt;
    bus.setup_cycles = su;
    bus.hold_cycles  = ho;
    bus.setup_vec    = SV;
    bus.hold_vec     = HV;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = keep;
    bus.cnt_upto     = ~cnt;
    bus.setup_cycles = ~su;
    bus.hold_cycles  = ~ho;
    bus.setup_vec    = 5'h00;
    bus.hold_vec     = 5'h1F;
  endtask

  task automatic run_vec(input vec_t v);
    int se, he, per, p, ec;
    se  = (v.su == 0) ? 1 : int'(v.su);
    he  = (v.ho == 0) ? 1 : int'(v.ho);
    per = se + he;
    start_seq(v.cnt, v.su, v.ho, 1'b0);
    for (int j = 0; j <= v.n_done; j++) begin
      if (j < v.n_done) begin
        p  = j % per;
        ec = j / per + ((p >= se) ? 1 : 0);
        chk("out_vec", 32'(bus.out_vec), 32'((p < se) ? SV : HV));
        chk("toggle_stb", 32'(bus.toggle_stb), 32'(p == se));
        chk("busy", 32'(bus.busy), 32'd1);
        chk("done_low", 32'(bus.done), 32'd0);
        chk("toggle_cnt", 32'(bus.toggle_cnt), 32'(ec));
        @(negedge clk);
      end else begin
        chk("done_high", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_out_vec", 32'(bus.out_vec), 32'(IV));
        chk("done_cnt", 32'(bus.toggle_cnt), 32'(v.cnt));
        chk("done_stb", 32'(bus.toggle_stb), 32'd0);
      end
    end
    @(negedge clk);
    chk("back_idle_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{cnt: 12'd3,    su: 4'd3,  ho: 4'd2,  n_done: 15};
    tbl[1] = '{cnt: 12'd2,    su: 4'd0,  ho: 4'd0,  n_done: 4};
    tbl[2] = '{cnt: 12'd0,    su: 4'd5,  ho: 4'd5,  n_done: 0};
    tbl[3] = '{cnt: 12'd1,    su: 4'd15, ho: 4'd15, n_done: 30};
    tbl[4] = '{cnt: 12'd4,    su: 4'd1,  ho: 4'd3,  n_done: 16};
    tbl[5] = '{cnt: 12'd4095, su: 4'd0,  ho: 4'd0,  n_done: 8190};

    reset            = 1'b1;
    bus.start        = 1'b0;
`ifdef TOGGLE_ABORT_EN
    bus.abort        = 1'b0;
`endif
    bus.cnt_upto     = 12'd7;
    bus.setup_cycles = 4'd1;
    bus.hold_cycles  = 4'd1;
    bus.setup_vec    = SV;
    bus.hold_vec     = HV;
    bus.idle_vec     = IV;

    #1;
    chk("rst_out_vec", 32'(bus.out_vec), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_stb", 32'(bus.toggle_stb), 32'd0);
    chk("rst_cnt", 32'(bus.toggle_cnt), 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("post_rst_idle_vec", 32'(bus.out_vec), 32'(IV));
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // start held through DONE must not retrigger
    start_seq(12'd1, 4'd1, 4'd1, 1'b1);
    step(2);
    chk("held_done", 32'(bus.done), 32'd1);
    step(3);
    chk("held_still_done", 32'(bus.done), 32'd1);
    chk("held_no_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    step(1);
    chk("drop_done_clr", 32'(bus.done), 32'd0);
    chk("drop_idle_busy", 32'(bus.busy), 32'd0);
    bus.cnt_upto     = 12'd1;
    bus.setup_cycles = 4'd1;
    bus.hold_cycles  = 4'd1;
    bus.setup_vec    = SV;
    bus.start        = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("retrig_busy", 32'(bus.busy), 32'd1);
    chk("retrig_out_vec", 32'(bus.out_vec), 32'(SV));
    chk("retrig_cnt_clr", 32'(bus.toggle_cnt), 32'd0);
    step(4);

    // asynchronous reset in the HOLD phase of toggle 2
    start_seq(12'd3, 4'd2, 4'd2, 1'b0);
    step(6);
    chk("mid_hold_cnt", 32'(bus.toggle_cnt), 32'd2);
    chk("mid_hold_vec", 32'(bus.out_vec), 32'(HV));
    reset = 1'b1;
    #1;
    chk("async_out_vec", 32'(bus.out_vec), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_cnt", 32'(bus.toggle_cnt), 32'd0);
    chk("async_done", 32'(bus.done), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_out_vec", 32'(bus.out_vec), 32'(IV));
    step(2);
    chk("rel_stays_idle", 32'(bus.busy), 32'd0);

`ifdef TOGGLE_ABORT_EN
    // abort in SETUP of toggle 2 of 5
    start_seq(12'd5, 4'd2, 4'd2, 1'b0);
    step(4);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("abort_done", 32'(bus.done), 32'd1);
    chk("abort_cnt", 32'(bus.toggle_cnt), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_stb", 32'(bus.toggle_stb), 32'd0);
    step(2);
    // abort on the SETUP->HOLD edge wins, no increment
    start_seq(12'd5, 4'd2, 4'd2, 1'b0);
    step(1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("abort_edge_cnt", 32'(bus.toggle_cnt), 32'd0);
    chk("abort_edge_stb", 32'(bus.toggle_stb), 32'd0);
    chk("abort_edge_done", 32'(bus.done), 32'd1);
    step(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
